// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit register: hold / shift right / shift left / parallel load, plus a saturating shift counter and done flag.
// Latency: 1 cycle, all outputs registered except sout_*; no backpressure, en acts as a stall.
module shift_register_univ #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    localparam int                CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;
    logic             done_nxt;

    // Counter stops at WIDTH; data keeps shifting past that point.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        q_nxt   = q;
        cnt_nxt = cnt;
        case (mode_t'(mode))
            MODE_SHR: begin
                q_nxt   = {sin_msb, q[WIDTH-1:1]};
                cnt_nxt = cnt_inc;
            end
            MODE_SHL: begin
                q_nxt   = {q[WIDTH-2:0], sin_lsb};
                cnt_nxt = cnt_inc;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q;
                cnt_nxt = cnt;
            end
        endcase
        done_nxt = (cnt_nxt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q    <= RESET_VALUE;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            q    <= RESET_VALUE;
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule
